// File: rtl/wb_stage_if.sv
// MEM -> WB handoff bundle for the write-back stage.
// The MEM stage (master) presents one instruction plus its datapath fields.
// The WB stage (slave) returns wb_allowin.
//   mem_valid          MEM presents an instruction this cycle
//   wb_allowin         WB can take it this cycle
//   instruction, pc    instruction word and its PC
//   alu_result         ALU result; the low 2 bits are the load byte offset
//   data_sram_rdata    word read from the data SRAM
//   control_reg_waddr  00 rd, 01 rt, 10 link register, 11 no write
//   control_reg_wdata  00 alu, 01 dmem, 10 lui imm, 11 pc+8
//   load_type          000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
interface wb_stage_if #(
   parameter int DATA_W = 32
);
   logic              mem_valid;
   logic              wb_allowin;
   logic [31:0]       instruction;
   logic [31:0]       pc;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] data_sram_rdata;
   logic [1:0]        control_reg_waddr;
   logic [1:0]        control_reg_wdata;
   logic [2:0]        load_type;

   modport master (
      output mem_valid, instruction, pc, alu_result, data_sram_rdata,
             control_reg_waddr, control_reg_wdata, load_type,
      input  wb_allowin
   );

   modport slave (
      input  mem_valid, instruction, pc, alu_result, data_sram_rdata,
             control_reg_waddr, control_reg_wdata, load_type,
      output wb_allowin
   );
endinterface

// File: rtl/wb_stage.sv
// Registered write-back stage of the 5-stage MIPS pipeline.
// Holds one instruction in a valid/allowin stage register, builds the
// register-file write (address, data, enable), exports a bypass value for
// ID-stage forwarding and counts retired instructions.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   mem            MEM -> WB handoff bundle (slave side)
//   wb_stall       hold the instruction in WB this cycle
//   wb_valid       stage register holds a valid instruction
//   reg_we/waddr/wdata  register-file write port
//   reg_raddr1/2   rs / rt fields of the latched instruction
//   fwd_valid/waddr/wdata  bypass value for the ID stage
//   inst_retired   retired-instruction counter (wraps)
module wb_stage #(
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 5,
   parameter int LINK_REG = 31,
   parameter int CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   wb_stage_if.slave          mem,
   input  logic               wb_stall,
   output logic               wb_valid,
   output logic               reg_we,
   output logic [RADDR_W-1:0] reg_waddr,
   output logic [DATA_W-1:0]  reg_wdata,
   output logic [RADDR_W-1:0] reg_raddr1,
   output logic [RADDR_W-1:0] reg_raddr2,
   output logic               fwd_valid,
   output logic [RADDR_W-1:0] fwd_waddr,
   output logic [DATA_W-1:0]  fwd_wdata,
   output logic [CNT_W-1:0]   inst_retired
);

   localparam logic [RADDR_W-1:0] LINK_ADDR = RADDR_W'(LINK_REG);

   localparam logic [1:0] WA_RD   = 2'b00;
   localparam logic [1:0] WA_RT   = 2'b01;
   localparam logic [1:0] WA_LINK = 2'b10;

   localparam logic [1:0] WD_ALU  = 2'b00;
   localparam logic [1:0] WD_DMEM = 2'b01;
   localparam logic [1:0] WD_LUI  = 2'b10;

   localparam logic [2:0] LT_LB  = 3'b001;
   localparam logic [2:0] LT_LBU = 3'b010;
   localparam logic [2:0] LT_LH  = 3'b011;
   localparam logic [2:0] LT_LHU = 3'b100;

   // Stage register. Opcode bits [31:26] are never consumed downstream,
   // so only [25:0] of the instruction word is kept.
   logic               valid_reg;
   logic [25:0]        inst_reg;
   logic [31:0]        pc_reg;
   logic [DATA_W-1:0]  alu_reg;
   logic [DATA_W-1:0]  rdata_reg;
   logic [1:0]         wa_code_reg;
   logic [1:0]         wd_code_reg;
   logic [2:0]         load_type_reg;
   logic [CNT_W-1:0]   cnt_reg;

   logic ready_go;
   logic allowin;
   logic accept;
   logic leave;
   logic has_dest;

   assign ready_go = !wb_stall;
   assign allowin  = !valid_reg || ready_go;
   assign accept   = mem.mem_valid && allowin;
   assign leave    = valid_reg && ready_go;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg     <= 1'b0;
         inst_reg      <= '0;
         pc_reg        <= '0;
         alu_reg       <= '0;
         rdata_reg     <= '0;
         wa_code_reg   <= '0;
         wd_code_reg   <= '0;
         load_type_reg <= '0;
         cnt_reg       <= '0;
      end else begin
         if (accept) begin
            valid_reg     <= 1'b1;
            inst_reg      <= mem.instruction[25:0];
            pc_reg        <= mem.pc;
            alu_reg       <= mem.alu_result;
            rdata_reg     <= mem.data_sram_rdata;
            wa_code_reg   <= mem.control_reg_waddr;
            wd_code_reg   <= mem.control_reg_wdata;
            load_type_reg <= mem.load_type;
         end else if (ready_go) begin
            // Either the instruction leaves with nothing behind it, or the
            // stage was already empty; both end with an empty stage.
            valid_reg <= 1'b0;
         end
         if (leave) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   // Load extension: split the read word into byte and half lanes, then
   // pick the lane addressed by the low bits of the effective address.
   logic [7:0]  byte_lane [4];
   logic [15:0] half_lane [2];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign byte_lane[gi] = rdata_reg[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign half_lane[gi] = rdata_reg[16*gi +: 16];
      end
   endgenerate

   logic [1:0]        off;
   logic [7:0]        sel_byte;
   logic [15:0]       sel_half;
   logic [DATA_W-1:0] load_val;

   assign off      = alu_reg[1:0];
   assign sel_byte = byte_lane[off];
   assign sel_half = half_lane[off[1]];

   always_comb begin
      load_val = rdata_reg;
      case (load_type_reg)
         LT_LB:   load_val = {{24{sel_byte[7]}}, sel_byte};
         LT_LBU:  load_val = {24'h0, sel_byte};
         LT_LH:   load_val = {{16{sel_half[15]}}, sel_half};
         LT_LHU:  load_val = {16'h0, sel_half};
         default: load_val = rdata_reg;
      endcase
   end

   logic [RADDR_W-1:0] waddr;
   logic [DATA_W-1:0]  wdata;

   always_comb begin
      waddr = '0;
      case (wa_code_reg)
         WA_RD:   waddr = inst_reg[15:11];
         WA_RT:   waddr = inst_reg[20:16];
         WA_LINK: waddr = LINK_ADDR;
         default: waddr = '0;
      endcase
   end

   always_comb begin
      wdata = alu_reg;
      case (wd_code_reg)
         WD_ALU:  wdata = alu_reg;
         WD_DMEM: wdata = load_val;
         WD_LUI:  wdata = {inst_reg[15:0], 16'h0000};
         default: wdata = pc_reg + 32'd8;
      endcase
   end

   // Code 11 drives address 0, so the r0 test alone also covers "no write".
   assign has_dest = valid_reg && (wa_code_reg != 2'b11) && (waddr != '0);

   assign mem.wb_allowin = allowin;
   assign wb_valid       = valid_reg;
   assign reg_we         = has_dest && ready_go;
   assign reg_waddr      = waddr;
   assign reg_wdata      = wdata;
   assign reg_raddr1     = inst_reg[25:21];
   assign reg_raddr2     = inst_reg[20:16];
   // Forwarding ignores the stall: a held producer still supplies its value.
   assign fwd_valid      = has_dest;
   assign fwd_waddr      = waddr;
   assign fwd_wdata      = wdata;
   assign inst_retired   = cnt_reg;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [1:0]  wa;
      logic [1:0]  wd;
      logic [2:0]  lt;
   } txn_t;

   typedef struct {
      bit          we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  rs;
      logic [4:0]  rt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_stall = 1'b0;
   logic        wb_valid, reg_we, fwd_valid;
   logic [4:0]  reg_waddr, reg_raddr1, reg_raddr2, fwd_waddr;
   logic [31:0] reg_wdata, fwd_wdata, inst_retired;

   // Second instance with a 4-bit counter to exercise wrap-around.
   logic        s_valid, s_we, s_fwd_valid;
   logic [4:0]  s_waddr, s_raddr1, s_raddr2, s_fwd_waddr;
   logic [31:0] s_wdata, s_fwd_wdata;
   logic [3:0]  s_retired;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   logic [31:0] model_cnt = 0;
   bit rand_stall_en = 0;

   wb_stage_if #(.DATA_W(32)) mif ();
   wb_stage_if #(.DATA_W(32)) sif ();

   assign sif.mem_valid         = mif.mem_valid;
   assign sif.instruction       = mif.instruction;
   assign sif.pc                = mif.pc;
   assign sif.alu_result        = mif.alu_result;
   assign sif.data_sram_rdata   = mif.data_sram_rdata;
   assign sif.control_reg_waddr = mif.control_reg_waddr;
   assign sif.control_reg_wdata = mif.control_reg_wdata;
   assign sif.load_type         = mif.load_type;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .reset(reset), .mem(mif.slave), .wb_stall(wb_stall),
      .wb_valid(wb_valid), .reg_we(reg_we), .reg_waddr(reg_waddr),
      .reg_wdata(reg_wdata), .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
      .fwd_valid(fwd_valid), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
      .inst_retired(inst_retired)
   );

   wb_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .mem(sif.slave), .wb_stall(wb_stall),
      .wb_valid(s_valid), .reg_we(s_we), .reg_waddr(s_waddr),
      .reg_wdata(s_wdata), .reg_raddr1(s_raddr1), .reg_raddr2(s_raddr2),
      .fwd_valid(s_fwd_valid), .fwd_waddr(s_fwd_waddr), .fwd_wdata(s_fwd_wdata),
      .inst_retired(s_retired)
   );

   // Reference model: what the register file should see for one instruction.
   function automatic exp_t model(input txn_t t);
      exp_t e;
      int unsigned off;
      logic [31:0] b, h, ld;
      off = t.alu % 4;
      b = (t.rdata >> (8 * off)) & 32'h0000_00FF;
      h = (t.rdata >> (16 * (off / 2))) & 32'h0000_FFFF;
      case (t.lt)
         3'd1:    ld = (b >= 32'd128)   ? b - 32'd256   : b;
         3'd2:    ld = b;
         3'd3:    ld = (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd4:    ld = h;
         default: ld = t.rdata;
      endcase
      case (t.wa)
         2'd0:    e.waddr = t.inst[15:11];
         2'd1:    e.waddr = t.inst[20:16];
         2'd2:    e.waddr = 5'd31;
         default: e.waddr = 5'd0;
      endcase
      case (t.wd)
         2'd0:    e.wdata = t.alu;
         2'd1:    e.wdata = ld;
         2'd2:    e.wdata = (t.inst & 32'h0000_FFFF) * 32'd65536;
         default: e.wdata = t.pc + 32'd8;
      endcase
      e.we = (t.wa != 2'd3) && (e.waddr != 5'd0);
      e.rs = t.inst[25:21];
      e.rt = t.inst[20:16];
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         check("inst_retired", inst_retired, model_cnt);
         check("inst_retired_w4", {28'h0, s_retired}, model_cnt & 32'hF);
         check("wb_allowin", {31'h0, mif.wb_allowin}, {31'h0, (!wb_valid || !wb_stall)});
         if (wb_valid) begin
            if (exp_q.size() == 0) begin
               check("orphan_wb_valid", {31'h0, wb_valid}, 32'h0);
            end else begin
               e = exp_q[0];
               check("fwd_valid", {31'h0, fwd_valid}, {31'h0, e.we});
               check("reg_raddr1", {27'h0, reg_raddr1}, {27'h0, e.rs});
               check("reg_raddr2", {27'h0, reg_raddr2}, {27'h0, e.rt});
               if (e.we) begin
                  check("fwd_waddr", {27'h0, fwd_waddr}, {27'h0, e.waddr});
                  check("fwd_wdata", fwd_wdata, e.wdata);
               end
               if (!wb_stall) begin
                  check("reg_we", {31'h0, reg_we}, {31'h0, e.we});
                  if (e.we) begin
                     check("reg_waddr", {27'h0, reg_waddr}, {27'h0, e.waddr});
                     check("reg_wdata", reg_wdata, e.wdata);
                  end
                  $display("retire #%0d we=%0b waddr=%0d wdata=%h", model_cnt + 1,
                           reg_we, reg_waddr, reg_wdata);
                  void'(exp_q.pop_front());
                  model_cnt = model_cnt + 1;
               end else begin
                  check("reg_we_stalled", {31'h0, reg_we}, 32'h0);
               end
            end
         end else begin
            check("reg_we_idle", {31'h0, reg_we}, 32'h0);
            check("fwd_valid_idle", {31'h0, fwd_valid}, 32'h0);
            if (exp_q.size() != 0)
               check("missing_wb_valid", {31'h0, wb_valid}, 32'h1);
         end
         // Reset is sampled at the next rising edge: the stage empties.
         if (reset) begin
            exp_q.delete();
            model_cnt = 0;
         end
      end
   end

   // Random stall generator, enabled only in the random phase.
   always @(posedge clk) begin
      #1;
      if (rand_stall_en) wb_stall = ($urandom_range(0, 3) == 0);
   end

   task automatic set_inputs(input txn_t t);
      mif.instruction       = t.inst;
      mif.pc                = t.pc;
      mif.alu_result        = t.alu;
      mif.data_sram_rdata   = t.rdata;
      mif.control_reg_waddr = t.wa;
      mif.control_reg_wdata = t.wd;
      mif.load_type         = t.lt;
   endtask

   // Present one instruction and return just after the edge that takes it.
   task automatic issue(input txn_t t);
      int waited;
      set_inputs(t);
      mif.mem_valid = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         if (mif.wb_allowin) begin
            exp_q.push_back(model(t));
            @(posedge clk);
            #1;
            mif.mem_valid = 1'b0;
            $display("issue inst=%h wa=%0d wd=%0d lt=%0d", t.inst, t.wa, t.wd, t.lt);
            return;
         end
         waited++;
         if (waited > 200) begin
            check("accept_timeout", 32'd0, 32'd1);
            mif.mem_valid = 1'b0;
            return;
         end
      end
   endtask

   function automatic txn_t mk(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] alu, input logic [31:0] rdata,
                               input logic [1:0] wa, input logic [1:0] wd,
                               input logic [2:0] lt);
      txn_t t;
      t.inst = inst; t.pc = pc; t.alu = alu; t.rdata = rdata;
      t.wa = wa; t.wd = wd; t.lt = lt;
      return t;
   endfunction

   function automatic txn_t rnd();
      return mk($urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
   endfunction

   initial begin
      int waited;
      mif.mem_valid = 1'b0;
      set_inputs(mk(0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // lw to rt=5
      issue(mk(32'h8C05_0000, 32'h0040_0000, 32'h0000_1000, 32'h8899_AABB, 2'b01, 2'b01, 3'd0));
      @(posedge clk); #1;
      // lb off 1/2/3, lbu off 3, lh off 2, lhu off 0
      issue(mk(32'h8009_0000, 32'h0, 32'h0000_2001, 32'h80FF_7F01, 2'b01, 2'b01, 3'd1));
      issue(mk(32'h8009_0000, 32'h0, 32'h0000_2002, 32'h80FF_7F01, 2'b01, 2'b01, 3'd1));
      issue(mk(32'h8009_0000, 32'h0, 32'h0000_2003, 32'h80FF_7F01, 2'b01, 2'b01, 3'd1));
      issue(mk(32'h9009_0000, 32'h0, 32'h0000_2003, 32'h80FF_7F01, 2'b01, 2'b01, 3'd2));
      issue(mk(32'h8409_0000, 32'h0, 32'h0000_2002, 32'h80FF_7F01, 2'b01, 2'b01, 3'd3));
      issue(mk(32'h9409_0000, 32'h0, 32'h0000_2000, 32'h80FF_7F01, 2'b01, 2'b01, 3'd4));
      // lui to r0 (no write, still retires), then jal
      issue(mk(32'h3C00_1234, 32'h0, 32'h0, 32'h0, 2'b01, 2'b10, 3'd0));
      issue(mk(32'h0C10_0004, 32'h0040_0010, 32'h0, 32'h0, 2'b10, 2'b11, 3'd0));

      // add rd=8 held for three stalled cycles, then released with a
      // back-to-back accept
      issue(mk(32'h0109_4020, 32'h0, 32'h1234_5678, 32'h0, 2'b00, 2'b00, 3'd0));
      wb_stall = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      wb_stall = 1'b0;
      issue(mk(32'h0129_5020, 32'h0, 32'hCAFE_0001, 32'h0, 2'b00, 2'b00, 3'd0));

      // Ten back-to-back instructions
      for (int i = 0; i < 10; i++) issue(rnd());
      @(posedge clk); #1;

      // Reset while a valid instruction is stalled
      issue(mk(32'h0109_4020, 32'h0, 32'hDEAD_BEEF, 32'h0, 2'b00, 2'b00, 3'd0));
      wb_stall = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      wb_stall = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Random phase with random stalls and idle gaps
      rand_stall_en = 1;
      for (int i = 0; i < 200; i++) begin
         issue(rnd());
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      rand_stall_en = 0;
      wb_stall = 1'b0;

      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the 5-stage MIPS pipeline. It sits between the MEM stage and the register file, replacing the purely combinational write-back mux with a registered stage.
- Holds one instruction in a valid/allowin pipeline register.
- Selects the write data and write address, and sign- or zero-extends sub-word loads.
- Suppresses writes to register 0.
- Exports bypass data for the ID-stage forwarding logic.
- Counts retired instructions.

Parameters:
DATA_W, 32, datapath width; load extension logic supports only 32.
RADDR_W, 5, register-file address width.
LINK_REG, 31, destination index for link writes (jal/jalr/bgezal).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
mem_valid  input  1  MEM stage presents an instruction
wb_allowin  output  1  WB can accept this cycle
instruction  input  32  instruction word
pc  input  32  instruction PC
alu_result  input  DATA_W  ALU result; low 2 bits are the load byte offset
data_sram_rdata  input  DATA_W  data SRAM read word
control_reg_waddr  input  2  00 rd, 01 rt, 10 LINK_REG, 11 no write
control_reg_wdata  input  2  00 alu, 01 dmem, 10 lui imm, 11 pc+8
load_type  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others treated as lw
wb_stall  input  1  hold WB (e.g. register-file port busy)
wb_valid  output  1  stage register holds a valid instruction
reg_we  output  1  register-file write enable
reg_waddr  output  RADDR_W  register-file write address
reg_wdata  output  DATA_W  register-file write data
reg_raddr1  output  RADDR_W  instruction[25:21] of the latched instruction (rs)
reg_raddr2  output  RADDR_W  instruction[20:16] of the latched instruction (rt)
fwd_valid  output  1  bypass value valid
fwd_waddr  output  RADDR_W  bypass destination
fwd_wdata  output  DATA_W  bypass value
inst_retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset (clk edge with reset=1) values:
  - wb_valid=0, inst_retired=0, all latched fields=0.
  - Hence reg_we=0, fwd_valid=0, reg_waddr=0, reg_wdata=0.
- Handshake:
  - Define ready_go = !wb_stall.
  - wb_allowin = !wb_valid | ready_go.
  - Accept when mem_valid & wb_allowin. On the next edge, wb_valid=1 and all inputs are latched. Data is registered, so latency is 1 cycle from acceptance.
  - When wb_valid & ready_go & !accept, wb_valid clears at the next edge.
  - While stalled, the stage register holds unchanged.
- Write data, combinational from latched fields:
  - alu: alu_result.
  - dmem: extended load value (see below).
  - lui: {instruction[15:0],16'h0}.
  - pc+8: pc+32'd8.
- Load extension, with off = alu_result[1:0]:
  - lw: whole word.
  - lb/lbu: byte off, i.e. bits [8*off+7 : 8*off]; sign-extended for lb, zero-extended for lbu.
  - lh/lhu: half selected by off[1]; sign-extended for lh, zero-extended for lhu; off[0] ignored.
- Write address:
  - Selected as rd (instruction[15:11]), rt (instruction[20:16]) or LINK_REG.
  - Code 11 means no write.
- Write enable:
  - reg_we = wb_valid & ready_go & (code != 11) & (reg_waddr != 0).
  - Exactly one write per instruction, issued in the cycle it leaves WB.
- Bypass:
  - fwd_valid = wb_valid & (code != 11) & (reg_waddr != 0). This is independent of the stall, so a stalled producer still forwards.
  - fwd_waddr = reg_waddr, fwd_wdata = reg_wdata.
- Retired counter:
  - Increments by 1 whenever wb_valid & ready_go, including no-write instructions.
  - Wraps modulo 2^CNT_W.
- Simultaneous events:
  - Leave and accept in the same cycle: wb_valid stays 1, new data is latched, and the counter increments.
  - Reset dominates everything, including mid-stall; no write is issued in the reset cycle's outputs after the edge.

Test Plan:
- Reset, then a lw with control_reg_wdata=01, load_type=000, rdata=32'h8899AABB, rt=5 -> the cycle after accept: reg_we=1, reg_waddr=5, reg_wdata=32'h8899AABB; inst_retired=1 on the next edge.
- lb and lbu, rdata=32'h80FF7F01, off=1/2/3 -> lb yields 32'h0000007F / FFFFFFFF / FFFFFF80. lbu at off=3 -> 32'h00000080. lh with off=2 -> FFFF80FF. lhu with off=0 -> 00007F01.
- lui with imm=16'h1234 to rt=0 -> reg_we=0 and fwd_valid=0, but inst_retired increments. jal with pc=32'h00400010 and waddr code 10 -> reg_waddr=31, reg_wdata=32'h00400018.
- Hold wb_stall=1 for 3 cycles with a valid add to rd=8 -> wb_allowin=0, reg_we=0, fwd_valid=1 with fwd_waddr=8 throughout, counter unchanged. On release: exactly one write, and a back-to-back accept keeps wb_valid=1.
- Stream of 10 instructions with mem_valid=1 and no stall -> 10 writes on consecutive cycles; inst_retired=10. With CNT_W=4 and a count of 15, the next retire gives 0.
- Assert reset during a stall with wb_valid=1 -> after the edge wb_valid=0, reg_we=0 and inst_retired=0; no write of the held instruction ever occurs.
